// File: rtl/gather_c_if.sv
// gather_c_if: PE-array / C-BRAM side bundle of the output-gather stage.
//   start_cal, c_outs       : pass request and result row from the array
//   c_ins, gather_done      : partial sum of the current row, end-of-pass pulse
//   bram_*_c                : C BRAM write port (bram_rddata_c reserved)
// The master modport is the array controller / BRAM side; slave is gather_c.
interface gather_c_if #(
  parameter int W       = 8,
  parameter int N       = 16,
  parameter int BRAM_W  = 256,
  parameter int BRAM_AW = 10
);
  logic                 start_cal;
  logic                 gather_done;
  logic [N*2*W-1:0]     c_outs;
  logic [N*2*W-1:0]     c_ins;
  logic                 bram_clk_c;
  logic                 bram_we_c;
  logic [BRAM_AW-1:0]   bram_addr_c;
  logic [BRAM_W-1:0]    bram_wrdata_c;
  logic [BRAM_W-1:0]    bram_rddata_c;

  modport master (
    output start_cal, c_outs, bram_rddata_c,
    input  gather_done, c_ins, bram_clk_c, bram_we_c, bram_addr_c, bram_wrdata_c
  );

  modport slave (
    input  start_cal, c_outs, bram_rddata_c,
    output gather_done, c_ins, bram_clk_c, bram_we_c, bram_addr_c, bram_wrdata_c
  );
endinterface

// File: rtl/gather_c.sv
// gather_c: output-gather stage of the systolic matrix-multiply accelerator.
// Accumulates DATA_A_SIZE_Y rows of N lanes (2W bits each) across the K passes
// of a column tile, then writes the finished tile to the C BRAM, one row/word.
// Ports:
//   clk, rst (async, active low)
//   bus          : gather_c_if.slave (start_cal, c_outs, c_ins, gather_done, bram_*_c)
//   debug_*      : internal buffer, FSM states, counters and pulses
module gather_c #(
  parameter int W             = 8,
  parameter int N             = 16,
  parameter int BRAM_W        = 256,
  parameter int BRAM_AW       = 10,
  parameter int DATA_A_SIZE_X = 64,
  parameter int DATA_A_SIZE_Y = 64,
  parameter int DATA_B_SIZE_X = 64,
  parameter int DATA_B_SIZE_Y = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  gather_c_if.slave                         bus,
  output logic [DATA_A_SIZE_Y*N*2*W-1:0]    debug_buffer,
  output logic [2:0]                        debug_state,
  output logic [2:0]                        debug_bram_state,
  output logic [N-1:0]                      debug_in_block_cnt,
  output logic [N-1:0]                      debug_write_back_cnt,
  output logic [DATA_B_SIZE_X/N-1:0]        debug_col_cnt,
  output logic [DATA_B_SIZE_Y/N-1:0]        debug_row_cnt,
  output logic                              debug_write_back,
  output logic                              debug_recieve_done,
  output logic                              debug_write_back_done
);
  localparam int LW = 2 * W;
  localparam int RW = $clog2(DATA_A_SIZE_Y);
  localparam int KP = DATA_A_SIZE_X / N;   // K passes per column tile
  localparam int CT = DATA_B_SIZE_X / N;   // column tiles
  localparam int KW = DATA_B_SIZE_Y / N;
  localparam int CW = DATA_B_SIZE_X / N;

  typedef enum logic [2:0] {
    IDLE = 3'd0, RECEIVE = 3'd1, WRITE_BACK = 3'd2, DONE = 3'd3
  } state_t;

  typedef enum logic [2:0] {
    B_IDLE = 3'd0, B_WRITE = 3'd1, B_DONE = 3'd2
  } bstate_t;

  state_t  state, state_nx;
  bstate_t bstate, bstate_nx;

  logic               start_q, start_rise;
  logic               capture, last_row, last_word, final_pass;
  logic [N-1:0]       in_block_cnt, wb_cnt;
  logic [KW-1:0]      row_cnt;
  logic [CW-1:0]      col_cnt;
  logic [RW-1:0]      rx_idx, wb_idx;
  logic [BRAM_W-1:0]  tile_buf [DATA_A_SIZE_Y];
  logic [BRAM_W-1:0]  row_base, row_sum;
  logic [BRAM_AW-1:0] wb_addr;
  logic               gather_done_q, we_q, recv_done_q, wb_done_q;
  logic [BRAM_AW-1:0] addr_q;
  logic [BRAM_W-1:0]  wrdata_q;
  logic               unused_rddata;

  assign rx_idx = in_block_cnt[RW-1:0];
  assign wb_idx = wb_cnt[RW-1:0];

  // Row 0 is captured on the same edge that leaves IDLE, so capture covers both states.
  always_comb begin
    start_rise = bus.start_cal & ~start_q;
    capture    = ((state == IDLE) & start_rise) | ((state == RECEIVE) & bus.start_cal);
    last_row   = capture & (in_block_cnt == N'(DATA_A_SIZE_Y - 1));
    last_word  = (state == WRITE_BACK) & (wb_cnt == N'(DATA_A_SIZE_Y - 1));
    final_pass = (row_cnt == KW'(KP - 1));
    state_nx   = state;
    case (state)
      IDLE, RECEIVE: begin
        if (last_row)     state_nx = final_pass ? WRITE_BACK : DONE;
        else if (capture) state_nx = RECEIVE;
      end
      WRITE_BACK: if (last_word) state_nx = DONE;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
    bstate_nx = B_IDLE;
    if (state_nx == WRITE_BACK) bstate_nx = B_WRITE;
    else if (last_word)         bstate_nx = B_DONE;
  end

  // First K pass of a tile starts from zero instead of the stale previous tile.
  always_comb begin
    row_sum  = '0;
    row_base = (row_cnt == '0) ? '0 : tile_buf[rx_idx];
    for (int unsigned j = 0; j < N; j++)
      row_sum[j*LW +: LW] = row_base[j*LW +: LW] + bus.c_outs[j*LW +: LW];
    wb_addr = BRAM_AW'(col_cnt) * BRAM_AW'(DATA_A_SIZE_Y) + BRAM_AW'(wb_cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      bstate <= B_IDLE;
    end else begin
      state  <= state_nx;
      bstate <= bstate_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q       <= 1'b0;
      in_block_cnt  <= '0;
      wb_cnt        <= '0;
      row_cnt       <= '0;
      col_cnt       <= '0;
      gather_done_q <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wrdata_q      <= '0;
      recv_done_q   <= 1'b0;
      wb_done_q     <= 1'b0;
      for (int unsigned i = 0; i < DATA_A_SIZE_Y; i++) tile_buf[i] <= '0;
    end else begin
      start_q       <= bus.start_cal;
      recv_done_q   <= last_row;
      wb_done_q     <= last_word;
      gather_done_q <= (state_nx == DONE);
      if (capture) begin
        tile_buf[rx_idx] <= row_sum;
        if (!last_row) in_block_cnt <= in_block_cnt + N'(1);
      end
      if (state == WRITE_BACK) begin
        we_q     <= 1'b1;
        addr_q   <= wb_addr;
        wrdata_q <= tile_buf[wb_idx];
        if (!last_word) wb_cnt <= wb_cnt + N'(1);
      end else begin
        we_q <= 1'b0;
      end
      if (state == DONE) begin
        in_block_cnt <= '0;
        wb_cnt       <= '0;
        row_cnt      <= final_pass ? '0 : row_cnt + KW'(1);
        if (final_pass)
          col_cnt <= (col_cnt == CW'(CT - 1)) ? '0 : col_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    debug_buffer = '0;
    for (int unsigned i = 0; i < DATA_A_SIZE_Y; i++)
      debug_buffer[i*BRAM_W +: BRAM_W] = tile_buf[i];
  end

  assign unused_rddata         = ^bus.bram_rddata_c;
  assign bus.c_ins             = tile_buf[rx_idx];
  assign bus.gather_done       = gather_done_q;
  assign bus.bram_clk_c        = clk;
  assign bus.bram_we_c         = we_q;
  assign bus.bram_addr_c       = addr_q;
  assign bus.bram_wrdata_c     = wrdata_q;
  assign debug_state           = state;
  assign debug_bram_state      = bstate;
  assign debug_in_block_cnt    = in_block_cnt;
  assign debug_write_back_cnt  = wb_cnt;
  assign debug_col_cnt         = col_cnt;
  assign debug_row_cnt         = row_cnt;
  assign debug_write_back      = (state == WRITE_BACK);
  assign debug_recieve_done    = recv_done_q;
  assign debug_write_back_done = wb_done_q;
endmodule

// File: tb/tb_gather_c.sv
// tb_gather_c: directed bench for gather_c with a tile-level accumulator model.
module tb_gather_c;
  localparam int W  = 8;
  localparam int N  = 16;
  localparam int BW = 256;
  localparam int AW = 10;
  localparam int RY = 64;
  localparam int KP = 4;
  localparam int CT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gather_c_if #(.W(W), .N(N), .BRAM_W(BW), .BRAM_AW(AW)) bus ();

  logic [RY*BW-1:0] debug_buffer;
  logic [2:0]       debug_state, debug_bram_state;
  logic [N-1:0]     debug_in_block_cnt, debug_write_back_cnt;
  logic [3:0]       debug_col_cnt, debug_row_cnt;
  logic             debug_write_back, debug_recieve_done, debug_write_back_done;

  gather_c #(.W(W), .N(N), .BRAM_W(BW), .BRAM_AW(AW), .DATA_A_SIZE_X(64),
             .DATA_A_SIZE_Y(RY), .DATA_B_SIZE_X(64), .DATA_B_SIZE_Y(64)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .debug_buffer(debug_buffer), .debug_state(debug_state),
    .debug_bram_state(debug_bram_state), .debug_in_block_cnt(debug_in_block_cnt),
    .debug_write_back_cnt(debug_write_back_cnt), .debug_col_cnt(debug_col_cnt),
    .debug_row_cnt(debug_row_cnt), .debug_write_back(debug_write_back),
    .debug_recieve_done(debug_recieve_done), .debug_write_back_done(debug_write_back_done)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wr_t;

  // Model: accumulated 16-bit lanes per tile row, pass/tile indices, expected writes.
  logic [15:0] acc [RY][N];
  int          k_pass, col_tile;
  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          wr_seen = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] row_word(input int r);
    logic [BW-1:0] v;
    for (int j = 0; j < N; j++) v[j*16 +: 16] = acc[r][j];
    return v;
  endfunction

  function automatic logic [15:0] buf_lane(input int r, input int j);
    return debug_buffer[(r*N + j)*16 +: 16];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < RY; r++)
      for (int j = 0; j < N; j++) acc[r][j] = 16'h0;
    k_pass = 0;
    col_tile = 0;
  endtask

  // Every BRAM write must match the next expected (address, tile row).
  always @(negedge clk) begin
    if (rst && bus.bram_we_c) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("bram_we_unexpected", BW'(bus.bram_we_c), '0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("bram_addr", BW'(bus.bram_addr_c), BW'(e.addr));
        check("bram_wrdata", bus.bram_wrdata_c, e.data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    bus.start_cal = 1'b0;
    bus.c_outs = '0;
    repeat (2) @(negedge clk);
    check("rst_gather_done", BW'(bus.gather_done), '0);
    check("rst_we", BW'(bus.bram_we_c), '0);
    check("rst_state", BW'(debug_state), '0);
    check("rst_col", BW'(debug_col_cnt), '0);
    check("rst_row", BW'(debug_row_cnt), '0);
    check("rst_buffer_or", BW'(|debug_buffer), '0);
    model_clear();
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Drive nrows rows starting at a negedge; gap_at>=0 drops start_cal for 2 cycles there.
  task automatic drive_rows(input logic [15:0] val, input bit rnd, input int nrows, input int gap_at);
    logic [15:0] nxt [N];
    for (int r = 0; r < nrows; r++) begin
      if (r == gap_at) begin
        bus.start_cal = 1'b0;
        repeat (2) @(negedge clk);
      end
      for (int j = 0; j < N; j++) begin
        nxt[j] = rnd ? 16'($urandom_range(0, 65535)) : val;
        bus.c_outs[j*16 +: 16] = nxt[j];
      end
      bus.start_cal = 1'b1;
      #1;
      check("c_ins", bus.c_ins, row_word(r));
      @(posedge clk);
      for (int j = 0; j < N; j++)
        acc[r][j] = ((k_pass == 0) ? 16'h0 : acc[r][j]) + nxt[j];
      @(negedge clk);
    end
    bus.start_cal = 1'b0;
  endtask

  task automatic full_pass(input logic [15:0] val, input bit rnd, input int gap_at);
    bit fin;
    int cnt;
    fin = (k_pass == KP - 1);
    drive_rows(val, rnd, RY, gap_at);
    check("recieve_done", BW'(debug_recieve_done), BW'(1));
    if (fin)
      for (int r = 0; r < RY; r++) exp_q.push_back('{addr: AW'(col_tile*RY + r), data: row_word(r)});
    cnt = 1;
    while (!bus.gather_done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("gather_done_latency", BW'(cnt), fin ? BW'(RY + 1) : BW'(1));
    @(negedge clk);
    check("gather_done_pulse", BW'(bus.gather_done), '0);
    k_pass = (k_pass + 1) % KP;
    if (k_pass == 0) col_tile = (col_tile + 1) % CT;
    check("row_cnt", BW'(debug_row_cnt), BW'(k_pass));
    check("col_cnt", BW'(debug_col_cnt), BW'(col_tile));
    check("state_idle", BW'(debug_state), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 1'b0;
    bus.start_cal = 1'b0;
    bus.c_outs = '0;
    bus.bram_rddata_c = '0;

    // Single non-final pass: no writes, lanes hold 3.
    do_reset();
    w0 = wr_seen;
    full_pass(16'h0003, 1'b0, -1);
    check("p1_lane_r10_j5", BW'(buf_lane(10, 5)), BW'(16'h0003));
    check("p1_lane_r63_j15", BW'(buf_lane(63, 15)), BW'(16'h0003));
    check("p1_row_cnt_lit", BW'(debug_row_cnt), BW'(1));
    check("p1_no_writes", BW'(wr_seen - w0), '0);

    // Four K passes 1..4: one tile of 0x000a words at addr 0..63.
    do_reset();
    w0 = wr_seen;
    for (int p = 1; p <= 4; p++) full_pass(16'(p), 1'b0, (p == 2) ? 20 : -1);
    check("p4_buffer_row0", debug_buffer[0 +: BW], {16{16'h000a}});
    check("p4_write_count", BW'(wr_seen - w0), BW'(64));
    check("p4_col_lit", BW'(debug_col_cnt), BW'(1));
    check("p4_pending", BW'(exp_q.size()), '0);

    // Full 16-pass run with random data, all four column tiles.
    do_reset();
    w0 = wr_seen;
    for (int p = 0; p < 16; p++) full_pass(16'h0, 1'b1, (p % 5 == 0) ? 40 : -1);
    check("full_write_count", BW'(wr_seen - w0), BW'(256));
    check("full_row_end", BW'(debug_row_cnt), '0);
    check("full_col_end", BW'(debug_col_cnt), '0);
    check("full_pending", BW'(exp_q.size()), '0);

    // Overflow wraps lane-wise modulo 2^16.
    do_reset();
    full_pass(16'hFFFF, 1'b0, -1);
    full_pass(16'h0002, 1'b0, -1);
    full_pass(16'h0000, 1'b0, -1);
    full_pass(16'h0000, 1'b0, -1);
    check("ovf_lane_r7_j3", BW'(buf_lane(7, 3)), BW'(16'h0001));
    check("ovf_pending", BW'(exp_q.size()), '0);

    // Reset at row 30 of a pass aborts and clears everything.
    do_reset();
    drive_rows(16'h0007, 1'b0, 30, -1);
    check("mid_in_block_cnt", BW'(debug_in_block_cnt), BW'(30));
    rst = 1'b0;
    #1;
    check("mid_rst_state", BW'(debug_state), '0);
    check("mid_rst_in_block", BW'(debug_in_block_cnt), '0);
    check("mid_rst_row", BW'(debug_row_cnt), '0);
    check("mid_rst_buffer_or", BW'(|debug_buffer), '0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    full_pass(16'h0005, 1'b0, -1);
    check("mid_after_r10", BW'(buf_lane(10, 0)), BW'(16'h0005));
    check("mid_after_r40", BW'(buf_lane(40, 9)), BW'(16'h0005));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
